// File: rtl/state_machine_pkg.sv
// Shared types and constants for the overlapping 0101 sequence detector.
// The transition function lives here so the detector and any reuse agree on it.
package state_machine_pkg;

  typedef enum logic [2:0] {
    S0 = 3'b000,
    S1 = 3'b001,
    S2 = 3'b010,
    S3 = 3'b011,
    S4 = 3'b100
  } state_e;

  localparam logic [3:0] PATTERN = 4'b0101;

  // PATTERN[3] is the oldest bit. Fallback states on a mismatch are the
  // longest proper suffix of the progress so far that is still a prefix.
  function automatic state_e next_state(input state_e cur, input logic x);
    state_e nxt;
    case (cur)
      S0:      nxt = (x == PATTERN[3]) ? S1 : S0;
      S1:      nxt = (x == PATTERN[2]) ? S2 : S1;
      S2:      nxt = (x == PATTERN[1]) ? S3 : S0;
      S3:      nxt = (x == PATTERN[0]) ? S4 : S1;
      S4:      nxt = (x == PATTERN[1]) ? S3 : S0;
      default: nxt = S0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/state_machine.sv
// Moore-type overlapping detector for the serial pattern 0101.
// y comes straight from a flop that is set whenever the FSM sits in S4.
module state_machine
  import state_machine_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic x,
  output logic y
);

  state_e state_q;
  state_e state_d;
  logic   y_q;
  logic   y_d;

  // y_d looks at the next state so the registered flag tracks S4 exactly.
  always_comb begin
    state_d = next_state(state_q, x);
    y_d     = (state_d == S4);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S0;
      y_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: tb/tb_state_machine.sv
// Directed table plus corner sequences and a randomised soak against a
// shift-register model of the last four post-reset samples.
module tb_state_machine;
  import state_machine_pkg::*;

  logic clk;
  logic reset;
  logic x;
  logic y;

  int n_checks;
  int n_fail;

  typedef struct {
    logic x;
    logic exp_y;
  } vec_t;

  vec_t tbl[22];

  logic [3:0] m_hist;
  int         m_cnt;
  logic       m_exp;

  state_machine dut (
    .clk   (clk),
    .reset (reset),
    .x     (x),
    .y     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected finish before it");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive x at the falling edge, check y shortly after the next rising edge.
  task automatic apply(input logic xv, input logic ey, input string nm);
    @(negedge clk);
    x = xv;
    @(posedge clk);
    #2;
    check(nm, {2'b00, y}, {2'b00, ey});
  endtask

  // Async reset pulse inside the low clock phase, then the edge after release.
  task automatic reset_pulse(input logic xv, input logic ey, input string nm);
    @(negedge clk);
    x = xv;
    reset = 1'b0;
    #1;
    check({nm, "_async_y"}, {2'b00, y}, 3'b000);
    check({nm, "_async_state"}, dut.state_q, S0);
    #3;
    reset = 1'b1;
    @(posedge clk);
    #2;
    check({nm, "_after_release"}, {2'b00, y}, {2'b00, ey});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    x        = 1'b0;
    m_hist   = 4'b0000;
    m_cnt    = 0;

    tbl = '{
      '{1'b0, 1'b0}, '{1'b1, 1'b0}, '{1'b0, 1'b0}, '{1'b1, 1'b1}, '{1'b1, 1'b0},
      '{1'b0, 1'b0}, '{1'b1, 1'b0}, '{1'b0, 1'b0}, '{1'b1, 1'b1}, '{1'b0, 1'b0},
      '{1'b1, 1'b1},
      '{1'b1, 1'b0},
      '{1'b0, 1'b0}, '{1'b1, 1'b0}, '{1'b1, 1'b0}, '{1'b0, 1'b0}, '{1'b1, 1'b0},
      '{1'b0, 1'b0}, '{1'b0, 1'b0}, '{1'b1, 1'b0}, '{1'b0, 1'b0}, '{1'b1, 1'b1}
    };

    // Reset state before any clock edge, then held across edges.
    #3;
    check("reset_no_clock_y", {2'b00, y}, 3'b000);
    check("reset_no_clock_state", dut.state_q, S0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      x = (i % 2 == 1);
      @(posedge clk);
      #2;
      check("reset_held_y", {2'b00, y}, 3'b000);
    end
    check("reset_held_state", dut.state_q, S0);
    reset = 1'b1;

    // Basic detect, overlap and non-match streams.
    for (int i = 0; i < 22; i++) begin
      apply(tbl[i].x, tbl[i].exp_y, $sformatf("table_%0d", i));
    end

    // y is high here; reset must clear it without a clock.
    reset_pulse(1'b1, 1'b0, "reset_from_s4");

    // Mid-pattern reset discards the 010 progress.
    apply(1'b0, 1'b0, "mid_0");
    apply(1'b1, 1'b0, "mid_01");
    apply(1'b0, 1'b0, "mid_010");
    reset_pulse(1'b1, 1'b0, "mid_reset");
    apply(1'b0, 1'b0, "restart_0");
    apply(1'b1, 1'b0, "restart_01");
    apply(1'b0, 1'b0, "restart_010");
    apply(1'b1, 1'b1, "restart_0101");
    apply(1'b1, 1'b0, "restart_drop");

    // Random soak with short and edge-spanning reset pulses.
    reset = 1'b0;
    m_cnt = 0;
    #1;
    reset = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      int r;
      @(negedge clk);
      x = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 99);
      if (r < 4) begin
        #1 reset = 1'b0;
        m_cnt = 0;
        #1 reset = 1'b1;
      end else if (r < 6) begin
        reset = 1'b0;
        m_cnt = 0;
      end
      @(posedge clk);
      if (reset) begin
        m_hist = {m_hist[2:0], x};
        if (m_cnt < 4) m_cnt++;
      end
      #2;
      m_exp = (m_cnt >= 4) && (m_hist == PATTERN);
      check($sformatf("soak_%0d", i), {2'b00, y}, {2'b00, m_exp});
      reset = 1'b1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
